// File: rtl/ascon_p_ctrl.sv
// rtl/ascon_p_ctrl.sv - Word-serial Ascon permutation sequencer; optional illegal-rounds err port via ASCON_P_CTRL_ERR_EN
module ascon_p_ctrl #(
  parameter int BW = 64
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_start,
  input  logic [3:0]    i_rounds,
  output logic          o_busy,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  input  logic [BW-1:0] i_in_data,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic [BW-1:0] o_out_data,
  output logic          o_out_last,
  output logic          o_dp_en,
  output logic [2:0]    o_dp_slice_idx,
  output logic [3:0]    o_dp_round,
  output logic [BW-1:0] o_dp_slice_in,
  input  logic [BW-1:0] i_dp_slice_out
`ifdef ASCON_P_CTRL_ERR_EN
  ,
  output logic          o_err
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_IN, S_LOAD, S_EVAL, S_OUT} state_t;

  state_t        r_state;
  logic [2:0]    r_c;
  logic [3:0]    r_i;
  logic [3:0]    r_nr;
  logic [BW-1:0] r_buf [0:4];

  logic          r_busy;
  logic          r_in_ready;
  logic          r_out_valid;
  logic [BW-1:0] r_out_data;
  logic          r_out_last;
  logic          r_dp_en;
  logic [2:0]    r_dp_slice_idx;
  logic [3:0]    r_dp_round;
  logic [BW-1:0] r_dp_slice_in;

  state_t        w_state_nx;
  logic [2:0]    w_c_nx;
  logic [3:0]    w_i_nx;
  logic [2:0]    w_sel;
  logic [3:0]    w_round_nx;
  logic [3:0]    w_nr_latch;
  logic          w_rounds_ok;
  logic          w_start_ok;
  logic          w_in_fire;
  logic          w_out_fire;

  assign w_rounds_ok = (i_rounds != 4'd0) && (i_rounds <= 4'd12);
  // Out-of-range round counts fall back to the full p12 permutation when not rejected
  assign w_nr_latch  = w_rounds_ok ? i_rounds : 4'd12;
`ifdef ASCON_P_CTRL_ERR_EN
  assign w_start_ok  = i_start && w_rounds_ok;
`else
  assign w_start_ok  = i_start;
`endif
  assign w_in_fire   = r_in_ready && i_in_valid;
  assign w_out_fire  = r_out_valid && i_out_ready;
  // EVAL phase 5 has no word of its own; clamp so buffer/slice selects stay in 0..4
  assign w_sel       = (w_c_nx > 3'd4) ? 3'd4 : w_c_nx;
  assign w_round_nx  = 4'd12 - r_nr + w_i_nx;

  // Next-state and counter decode; outputs are registered from these values
  always_comb begin
    w_state_nx = r_state;
    w_c_nx     = r_c;
    w_i_nx     = r_i;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) begin
          w_state_nx = S_IN;
          w_c_nx     = 3'd0;
        end
      end
      S_IN: begin
        if (w_in_fire) begin
          if (r_c == 3'd4) begin
            w_state_nx = S_LOAD;
            w_c_nx     = 3'd0;
            w_i_nx     = 4'd0;
          end else begin
            w_c_nx = r_c + 3'd1;
          end
        end
      end
      S_LOAD: begin
        if (r_c == 3'd4) begin
          w_state_nx = S_EVAL;
          w_c_nx     = 3'd0;
        end else begin
          w_c_nx = r_c + 3'd1;
        end
      end
      S_EVAL: begin
        if (r_c == 3'd5) begin
          w_c_nx = 3'd0;
          if (r_i == r_nr - 4'd1) begin
            w_state_nx = S_OUT;
          end else begin
            w_state_nx = S_LOAD;
            w_i_nx     = r_i + 4'd1;
          end
        end else begin
          w_c_nx = r_c + 3'd1;
        end
      end
      S_OUT: begin
        if (w_out_fire) begin
          if (r_c == 3'd4) begin
            w_state_nx = S_IDLE;
            w_c_nx     = 3'd0;
          end else begin
            w_c_nx = r_c + 3'd1;
          end
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_c_nx     = 3'd0;
        w_i_nx     = 4'd0;
      end
    endcase
  end

  // FSM state, word buffer and registered outputs; reset discards any in-flight state
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state        <= S_IDLE;
      r_c            <= 3'd0;
      r_i            <= 4'd0;
      r_nr           <= 4'd0;
      for (int k = 0; k < 5; k++) r_buf[k] <= '0;
      r_busy         <= 1'b0;
      r_in_ready     <= 1'b0;
      r_out_valid    <= 1'b0;
      r_out_data     <= '0;
      r_out_last     <= 1'b0;
      r_dp_en        <= 1'b0;
      r_dp_slice_idx <= 3'd0;
      r_dp_round     <= 4'd0;
      r_dp_slice_in  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_c     <= w_c_nx;
      r_i     <= w_i_nx;

      if ((r_state == S_IDLE) && w_start_ok) r_nr <= w_nr_latch;
      if (w_in_fire) r_buf[r_c] <= i_in_data;
      // The datapath output lags the slice select by one cycle, hence the c-1 slot
      if ((r_state == S_EVAL) && (r_c != 3'd0)) r_buf[r_c - 3'd1] <= i_dp_slice_out;

      r_busy      <= (w_state_nx != S_IDLE);
      r_in_ready  <= (w_state_nx == S_IN);
      r_out_valid <= (w_state_nx == S_OUT);
      r_out_last  <= (w_state_nx == S_OUT) && (w_c_nx == 3'd4);
      r_out_data  <= (w_state_nx == S_OUT) ? r_buf[w_sel] : '0;
      r_dp_en     <= (w_state_nx == S_LOAD);
      r_dp_slice_in <= (w_state_nx == S_LOAD) ? r_buf[w_sel] : '0;
      if ((w_state_nx == S_LOAD) || (w_state_nx == S_EVAL)) begin
        r_dp_slice_idx <= w_sel;
        r_dp_round     <= w_round_nx;
      end else begin
        r_dp_slice_idx <= 3'd0;
        r_dp_round     <= 4'd0;
      end
    end
  end

`ifdef ASCON_P_CTRL_ERR_EN
  logic r_err;

  // One-cycle pulse when a start carries an unusable round count
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_err <= 1'b0;
    end else begin
      r_err <= (r_state == S_IDLE) && i_start && !w_rounds_ok;
    end
  end

  assign o_err = r_err;
`endif

  assign o_busy         = r_busy;
  assign o_in_ready     = r_in_ready;
  assign o_out_valid    = r_out_valid;
  assign o_out_data     = r_out_data;
  assign o_out_last     = r_out_last;
  assign o_dp_en        = r_dp_en;
  assign o_dp_slice_idx = r_dp_slice_idx;
  assign o_dp_round     = r_dp_round;
  assign o_dp_slice_in  = r_dp_slice_in;

endmodule

// File: tb/tb_ascon_p_ctrl.sv
// tb/tb_ascon_p_ctrl.sv - Scoreboard bench for ascon_p_ctrl with a word-serial datapath stub
module tb_ascon_p_ctrl;

  typedef logic [4:0][63:0] st_t;
  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  rounds = 4'd0;
  logic        busy;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = 64'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic        out_last;
  logic        dp_en;
  logic [2:0]  dp_slice_idx;
  logic [3:0]  dp_round;
  logic [63:0] dp_slice_in;
  logic [63:0] dp_slice_out;
`ifdef ASCON_P_CTRL_ERR_EN
  logic        err;
`endif

  int   errors = 0;
  int   checks = 0;
  int   n_out = 0;
  exp_t exp_q[$];
  int   round_log[$];

  always #5 clk = ~clk;

  ascon_p_ctrl #(.BW(64)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_start(start), .i_rounds(rounds), .o_busy(busy),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data), .o_out_last(out_last),
    .o_dp_en(dp_en), .o_dp_slice_idx(dp_slice_idx), .o_dp_round(dp_round),
    .o_dp_slice_in(dp_slice_in), .i_dp_slice_out(dp_slice_out)
`ifdef ASCON_P_CTRL_ERR_EN
    , .o_err(err)
`endif
  );

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [7:0] rc(input int r);
    return 8'(((15 - r) << 4) | r);
  endfunction

  // Ascon substitution plus linear diffusion layer (constant addition excluded)
  function automatic st_t sl(input st_t x);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    x0 = x[0]; x1 = x[1]; x2 = x[2]; x3 = x[3]; x4 = x[4];
    x0 ^= x4; x4 ^= x3; x2 ^= x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
    x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
    x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
    x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
    x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
    x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
    x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
    return {x4, x3, x2, x1, x0};
  endfunction

  // Golden Ascon-p with nr rounds: last nr constants of the p12 schedule
  function automatic st_t ascon_p(input st_t x, input int nr);
    for (int r = 12 - nr; r < 12; r++) begin
      x[2] = x[2] ^ {56'd0, rc(r)};
      x = sl(x);
    end
    return x;
  endfunction

  // Datapath stub: per-word load with constant on word 2, registered one-word output
  st_t dp_s;
  st_t dp_p;
  assign dp_p = sl(dp_s);
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dp_s <= '0;
      dp_slice_out <= 64'd0;
    end else if (dp_slice_idx <= 3'd4) begin
      if (dp_en)
        dp_s[dp_slice_idx] <= dp_slice_in ^ ((dp_slice_idx == 3'd2) ? {56'd0, rc(int'(dp_round))} : 64'd0);
      dp_slice_out <= dp_p[dp_slice_idx];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: pops the scoreboard on each output handshake, checks stall stability
  initial begin
    logic        prev_stall;
    logic [63:0] prev_data;
    logic        prev_last;
    exp_t        e;
    prev_stall = 1'b0;
    prev_data = 64'd0;
    prev_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid_held", 64'(out_valid), 64'd1);
          check("stall_data_stable", out_data, prev_data);
          check("stall_last_stable", 64'(out_last), 64'(prev_last));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL out_unexpected: got %h expected no word", out_data);
          end else begin
            e = exp_q.pop_front();
            check("out_data", out_data, e.data);
            check("out_last", 64'(out_last), 64'(e.last));
          end
          n_out++;
        end
        if (dp_en && dp_slice_idx == 3'd0) round_log.push_back(int'(dp_round));
        prev_stall = out_valid && !out_ready;
        prev_data = out_data;
        prev_last = out_last;
      end
    end
  end

  task automatic do_start(input logic [3:0] rin);
    rounds = rin;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("in_ready_after_start", 64'(in_ready), 64'd1);
    check("busy_after_start", 64'(busy), 64'd1);
  endtask

  // Feed five words; optional 2-cycle gap before word 2 with a stray start pulse
  task automatic feed(input st_t w, input bit gaps);
    int cnt;
    for (int k = 0; k < 5; k++) begin
      if (gaps && k == 2) begin
        in_valid = 1'b0;
        in_data = 64'd0;
        start = 1'b1;
        rounds = 4'd3;
        repeat (2) begin @(posedge clk); #1; end
        start = 1'b0;
        check("in_ready_after_gap", 64'(in_ready), 64'd1);
      end
      in_valid = 1'b1;
      in_data = w[k];
      cnt = 0;
      while (!in_ready && cnt < 20) begin @(posedge clk); #1; cnt++; end
      if (cnt >= 20) check("in_ready_timeout", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_data = 64'd0;
  endtask

  task automatic run(input st_t w, input logic [3:0] rin, input bit gaps, input bit bp, input bit rnd_out);
    int   nr, lat, base, hold, cyc;
    st_t  r;
    nr = (rin == 4'd0 || rin > 4'd12) ? 12 : int'(rin);
    r = ascon_p(w, nr);
    for (int k = 0; k < 5; k++) exp_q.push_back('{data: r[k], last: (k == 4)});
    round_log.delete();
    base = n_out;
    do_start(rin);
    feed(w, gaps);
    lat = 0;
    while (!out_valid && lat < 300) begin @(posedge clk); #1; lat++; end
    check("latency", 64'(lat), 64'(11 * nr));
    check("round_count", 64'(round_log.size()), 64'(nr));
    for (int j = 0; j < round_log.size() && j < nr; j++)
      check("dp_round", 64'(round_log[j]), 64'(12 - nr + j));
    hold = 0;
    cyc = 0;
    while ((n_out - base) < 5 && cyc < 400) begin
      if (bp && (n_out - base) == 2 && hold < 3) begin
        out_ready = 1'b0;
        hold++;
      end else if (rnd_out) begin
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        out_ready = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b0;
    check("out_words_drained", 64'(n_out - base), 64'd5);
    check("busy_after_out", 64'(busy), 64'd0);
    check("out_valid_after_out", 64'(out_valid), 64'd0);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_out_last"}, 64'(out_last), 64'd0);
    check({tag, "_out_data"}, out_data, 64'd0);
    check({tag, "_dp_en"}, 64'(dp_en), 64'd0);
    check({tag, "_dp_slice_idx"}, 64'(dp_slice_idx), 64'd0);
    check({tag, "_dp_round"}, 64'(dp_round), 64'd0);
    check({tag, "_dp_slice_in"}, dp_slice_in, 64'd0);
`ifdef ASCON_P_CTRL_ERR_EN
    check({tag, "_err"}, 64'(err), 64'd0);
`endif
  endtask

  function automatic st_t rand_state();
    st_t s;
    for (int k = 0; k < 5; k++) s[k] = {$urandom, $urandom};
    return s;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    st_t w0, w1, w2;
    #12;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;

    w0 = '0;
    run(w0, 4'd12, 1'b0, 1'b0, 1'b0);

    w1 = '0;
    w1[0] = 64'h0123456789ABCDEF;
    w1[4] = 64'h1;
    run(w1, 4'd6, 1'b0, 1'b0, 1'b0);

    run(rand_state(), 4'd4, 1'b0, 1'b1, 1'b0);

    run(w1, 4'd6, 1'b1, 1'b0, 1'b0);

    w2 = rand_state();
    do_start(4'd12);
    feed(w2, 1'b0);
    repeat (63) @(posedge clk);
    #2;
    check("pre_reset_busy", 64'(busy), 64'd1);
    check("pre_reset_dp_en", 64'(dp_en), 64'd0);
    check("pre_reset_idx", 64'(dp_slice_idx), 64'd3);
    rstn = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("after_reset");

    run(rand_state(), 4'd8, 1'b0, 1'b0, 1'b0);

`ifdef ASCON_P_CTRL_ERR_EN
    rounds = 4'd13;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("err_pulse", 64'(err), 64'd1);
    check("err_busy", 64'(busy), 64'd0);
    check("err_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    check("err_one_cycle", 64'(err), 64'd0);
    check("err_still_idle", 64'(busy), 64'd0);
`else
    run(w0, 4'd0, 1'b0, 1'b0, 1'b0);
`endif

    for (int t = 0; t < 6; t++)
      run(rand_state(), 4'($urandom_range(1, 12)), bit'($urandom_range(0, 1)), 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ascon_p_ctrl.md
# ascon_p_ctrl

Sequencer for the word-serial Ascon permutation datapath (5 × 64-bit state words, one word loaded or evaluated per cycle, round constant injected when word 2 is loaded, registered one-word output). It accepts a 320-bit state as five words over a valid/ready stream and holds the words in its own buffer. It drives the datapath through load/evaluate phases for 1–12 rounds (p12/p8/p6 and others), then streams the permuted state back out. It sits between the AEAD/hash mode FSM and the permutation datapath.

## Interface
Parameters:
- BW, 64, word width; must be 64.

Ports:
- clk  in  1  system clock, rising edge
- rstn  in  1  asynchronous active-low reset
- start  in  1  start request; sampled only in IDLE
- rounds  in  4  number of rounds nr, sampled with start
- busy  out  1  high in every state except IDLE
- in_valid  in  1  input word valid
- in_ready  out  1  high in IN state
- in_data  in  BW  input state word; order is word 0 first, word 4 last
- out_valid  out  1  high in OUT state
- out_ready  in  1  consumer accepts word
- out_data  out  BW  buf[out_idx]; word 0 first
- out_last  out  1  out_valid while word 4 is presented
- dp_en  out  1  datapath load enable
- dp_slice_idx  out  3  datapath word select, 0..4
- dp_round  out  4  datapath round-constant index, 0..11
- dp_slice_in  out  BW  word to load
- dp_slice_out  in  BW  registered datapath output
- err  out  1  illegal-rounds pulse; exists only with ASCON_P_CTRL_ERR_EN

## Operation
- Storage: buf[0..4] (64-bit each), round counter i (0..nr-1), phase counter c (0..5), latched nr.
- States: IDLE, IN, LOAD, EVAL, OUT.
- IDLE: when start is high, latch nr and go to IN with c=0. start is ignored in every other state.
- IN: in_ready=1. On in_valid&in_ready, write buf[c] and increment c. After word 4 is accepted, go to LOAD with i=0 and c=0.
- LOAD (5 cycles, c=0..4): dp_en=1, dp_slice_idx=c, dp_slice_in=buf[c], dp_round=12−nr+i. At c=4, go to EVAL with c=0.
- EVAL (6 cycles, c=0..5):
  - dp_en=0.
  - dp_slice_idx=c for c≤4; holds 4 at c=5.
  - For c≥1, capture dp_slice_out into buf[c−1] at the end of the cycle.
  - At c=5: if i=nr−1, go to OUT with c=0; otherwise i+1 and go to LOAD.
- OUT: out_data=buf[c]. On out_valid&out_ready, c+1. After word 4 is accepted, go to IDLE.
- dp_round arithmetic is 4-bit; for legal nr the range is 0..11, with no wrap.
- In states other than LOAD: dp_en=0, dp_slice_in=0. In IDLE, IN and OUT: dp_slice_idx=0, dp_round=0.
- Reset (asynchronous, any state, including mid-round):
  - State returns to IDLE.
  - Buffer and counters clear.
  - A partially processed state is discarded; no output is produced.

## Timing
- Reset values: busy=0, in_ready=0, out_valid=0, out_last=0, out_data=0, dp_en=0, dp_slice_idx=0, dp_round=0, dp_slice_in=0, err=0.
- start → in_ready: 1 cycle (IN entered on the edge that samples start).
- One round = 11 cycles (5 LOAD + 6 EVAL).
- out_valid rises exactly 11·nr edges after the edge that accepts input word 4. Examples: p12 = 132, p8 = 88, p6 = 66.
- Input and output are full-throughput when unthrottled: 1 word per cycle.
- Back-pressure:
  - out_data and out_last stay stable while out_valid=1 and out_ready=0.
  - in_valid low stalls IN indefinitely.
- Minimum start-to-start interval: 1 (IDLE) + 5 (IN) + 11·nr + 5 (OUT).

## Configuration
- ASCON_P_CTRL_ERR_EN defined:
  - A start with rounds=0 or rounds>12 is rejected: err pulses high for 1 cycle, the FSM stays in IDLE, and in_ready stays low.
  - Legal starts behave as above.
- ASCON_P_CTRL_ERR_EN undefined:
  - No err port.
  - rounds=0 or rounds>12 is latched as nr=12.

## Test plan
- All-zero state, rounds=12, unthrottled → first LOAD dp_round=0 and last LOAD dp_round=11. out_valid appears 132 edges after word 4 is accepted. The five words match the golden Ascon-p12 model of all-zero input.
- Words 0x0123456789ABCDEF, 0, 0, 0, 0x1 with rounds=6 → dp_round sequence is 6,7,…,11. out_valid after 66 edges; output matches the golden p6 result.
- Output back-pressure: hold out_ready=0 for 3 cycles on word 2 → out_data is unchanged for all 3 cycles. out_last is asserted only on word 4, then busy=0.
- Input gaps: insert 2 idle cycles of in_valid=0 between words 1 and 2, and pulse start during IN → extra start is ignored. Result is identical to the unstalled run.
- Reset asserted at EVAL c=3 of round 5 → all outputs are at reset values asynchronously. A new rounds=8 run afterwards produces correct p8 output 88 edges after the input.
- With ASCON_P_CTRL_ERR_EN: start with rounds=13 → err is high for exactly 1 cycle, busy=0, in_ready=0. Without the macro: rounds=0 → output equals the p12 result.
